// File: rtl/csc_pkg.sv
// Shared definitions for the RGB to YCbCr 4:2:2 converter: matrix encodings,
// Q.12 coefficient sets and a coefficient lookup helper.
package csc_pkg;

  localparam int COEF_FRAC = 12;
  localparam int COEF_W    = 14;

  typedef enum logic {
    CSC_BT601 = 1'b0,
    CSC_BT709 = 1'b1
  } csc_mode_e;

  typedef enum logic [1:0] {
    CSC_Y  = 2'd0,
    CSC_CB = 2'd1,
    CSC_CR = 2'd2
  } csc_comp_e;

  typedef logic signed [COEF_W-1:0] coef_t;

  typedef struct packed {
    coef_t kr;
    coef_t kg;
    coef_t kb;
  } coef3_t;

  localparam coef3_t COEF_Y_601  = '{kr: 14'sd1052, kg: 14'sd2065,  kb: 14'sd401};
  localparam coef3_t COEF_CB_601 = '{kr: -14'sd607, kg: -14'sd1192, kb: 14'sd1799};
  localparam coef3_t COEF_CR_601 = '{kr: 14'sd1799, kg: -14'sd1507, kb: -14'sd292};
  localparam coef3_t COEF_Y_709  = '{kr: 14'sd750,  kg: 14'sd2515,  kb: 14'sd254};
  localparam coef3_t COEF_CB_709 = '{kr: -14'sd413, kg: -14'sd1384, kb: 14'sd1799};
  localparam coef3_t COEF_CR_709 = '{kr: 14'sd1799, kg: -14'sd1634, kb: -14'sd164};

  function automatic coef3_t coef_sel(input csc_mode_e mode, input csc_comp_e comp);
    coef3_t k;
    k = (mode == CSC_BT709) ? COEF_Y_709 : COEF_Y_601;
    case (comp)
      CSC_CB:  k = (mode == CSC_BT709) ? COEF_CB_709 : COEF_CB_601;
      CSC_CR:  k = (mode == CSC_BT709) ? COEF_CR_709 : COEF_CR_601;
      default: ;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/csc_mac3.sv
// Two-stage signed 3-term multiply-accumulate: products are registered, then
// summed with rounding, shifted out of Q.12, offset and saturated to DW bits.
module csc_mac3
  import csc_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [DW-1:0] c,
  input  coef3_t        coef,
  input  logic [DW-1:0] offset,
  output logic [DW-1:0] res
);

  localparam int PW = DW + 1 + COEF_W;
  localparam int AW = PW + 2;
  localparam logic signed [AW-1:0] ROUND   = AW'(1 << (COEF_FRAC - 1));
  localparam logic signed [AW-1:0] MAX_VAL = AW'((1 << DW) - 1);

  logic signed [PW-1:0] prod_a, prod_b, prod_c;
  logic signed [AW-1:0] acc, val;
  logic [DW-1:0] sat;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod_a <= '0;
      prod_b <= '0;
      prod_c <= '0;
    end else begin
      prod_a <= PW'($signed({1'b0, a})) * PW'(coef.kr);
      prod_b <= PW'($signed({1'b0, b})) * PW'(coef.kg);
      prod_c <= PW'($signed({1'b0, c})) * PW'(coef.kb);
    end
  end

  // Arithmetic shift floors negative sums, so rounding is half-up throughout.
  always_comb begin
    acc = AW'(prod_a) + AW'(prod_b) + AW'(prod_c) + ROUND;
    val = (acc >>> COEF_FRAC) + $signed(AW'(offset));
    sat = val[DW-1:0];
    if (val[AW-1]) begin
      sat = '0;
    end else if (val > MAX_VAL) begin
      sat = '1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res <= '0;
    end else begin
      res <= sat;
    end
  end

endmodule

// File: rtl/csc_rgb2ycc422_p.sv
// Streaming RGB 4:4:4 to YCbCr 4:2:2 converter with per-frame BT.601/BT.709 select.
// Define CSC_DE_GATE_EN to force blanking-level Y/C outputs whenever de_out is low.
module csc_rgb2ycc422_p
  import csc_pkg::*;
#(
  parameter int DW       = 8,
  parameter bit CR_FIRST = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          csc_mode_in,
  input  logic [DW-1:0] r_in,
  input  logic [DW-1:0] g_in,
  input  logic [DW-1:0] b_in,
  input  logic          de_in,
  input  logic          hsync_in,
  input  logic          vsync_in,
  output logic [DW-1:0] y_out,
  output logic [DW-1:0] c_out,
  output logic          cr_flag_out,
  output logic          de_out,
  output logic          hsync_out,
  output logic          vsync_out
);

  localparam logic [DW-1:0] Y_OFF = DW'(16 << (DW - 8));
  localparam logic [DW-1:0] C_OFF = DW'(128 << (DW - 8));

  typedef struct packed {
    logic [DW-1:0] r;
    logic [DW-1:0] g;
    logic [DW-1:0] b;
    logic          de;
    logic          hs;
    logic          vs;
    logic          even;
    csc_mode_e     mode;
  } pix_t;

  function automatic logic [DW-1:0] avg2(input logic [DW-1:0] x, input logic [DW-1:0] y);
    logic [DW:0] s;
    s = {1'b0, x} + {1'b0, y} + (DW+1)'(1);
    return s[DW:1];
  endfunction

  pix_t s1, s2;
  logic odd_next;
  csc_mode_e mode_q, mode_now;
  logic de_rise, vs_rise, pix_even, partner;

  // s1 holds the previous input sample, so it doubles as the edge detector.
  always_comb begin
    de_rise  = de_in & ~s1.de;
    vs_rise  = vsync_in & ~s1.vs;
    pix_even = de_rise | ~odd_next;
    mode_now = vs_rise ? csc_mode_e'(csc_mode_in) : mode_q;
    partner  = s1.de & ~s1.even;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1       <= '0;
      s2       <= '0;
      odd_next <= 1'b0;
      mode_q   <= CSC_BT601;
    end else begin
      s1.r    <= r_in;
      s1.g    <= g_in;
      s1.b    <= b_in;
      s1.de   <= de_in;
      s1.hs   <= hsync_in;
      s1.vs   <= vsync_in;
      s1.even <= de_in & pix_even;
      s1.mode <= mode_now;
      mode_q  <= mode_now;
      if (de_in) begin
        odd_next <= pix_even;
      end
      s2 <= s1;
    end
  end

  logic [DW-1:0] s3_r, s3_g, s3_b, avg_r, avg_g, avg_b;
  logic s3_cr, s3_de, s3_hs, s3_vs;
  csc_mode_e s3_mode;

  // The pair average is formed when the even pixel sits in s2 and its odd
  // partner in s1; the odd pixel then reuses the held average.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s3_r    <= '0;
      s3_g    <= '0;
      s3_b    <= '0;
      avg_r   <= '0;
      avg_g   <= '0;
      avg_b   <= '0;
      s3_cr   <= 1'b0;
      s3_de   <= 1'b0;
      s3_hs   <= 1'b0;
      s3_vs   <= 1'b0;
      s3_mode <= CSC_BT601;
    end else begin
      s3_r    <= s2.r;
      s3_g    <= s2.g;
      s3_b    <= s2.b;
      s3_cr   <= s2.even ? CR_FIRST : ~CR_FIRST;
      s3_de   <= s2.de;
      s3_hs   <= s2.hs;
      s3_vs   <= s2.vs;
      s3_mode <= s2.mode;
      if (s2.even) begin
        avg_r <= avg2(s2.r, partner ? s1.r : s2.r);
        avg_g <= avg2(s2.g, partner ? s1.g : s2.g);
        avg_b <= avg2(s2.b, partner ? s1.b : s2.b);
      end
    end
  end

  logic [DW-1:0] y_res, cb_res, cr_res;

  csc_mac3 #(.DW(DW)) u_mac_y (
    .clk(clk), .rst(rst), .a(s3_r), .b(s3_g), .c(s3_b),
    .coef(coef_sel(s3_mode, CSC_Y)), .offset(Y_OFF), .res(y_res)
  );

  csc_mac3 #(.DW(DW)) u_mac_cb (
    .clk(clk), .rst(rst), .a(avg_r), .b(avg_g), .c(avg_b),
    .coef(coef_sel(s3_mode, CSC_CB)), .offset(C_OFF), .res(cb_res)
  );

  csc_mac3 #(.DW(DW)) u_mac_cr (
    .clk(clk), .rst(rst), .a(avg_r), .b(avg_g), .c(avg_b),
    .coef(coef_sel(s3_mode, CSC_CR)), .offset(C_OFF), .res(cr_res)
  );

  logic [3:0] ctl_d4, ctl_d5;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctl_d4 <= '0;
      ctl_d5 <= '0;
    end else begin
      ctl_d4 <= {s3_cr, s3_de, s3_hs, s3_vs};
      ctl_d5 <= ctl_d4;
    end
  end

  // Gated blanking levels are suppressed during reset so outputs read zero.
  always_comb begin
    cr_flag_out = ctl_d5[3];
    de_out      = ctl_d5[2];
    hsync_out   = ctl_d5[1];
    vsync_out   = ctl_d5[0];
    y_out       = y_res;
    c_out       = ctl_d5[3] ? cr_res : cb_res;
`ifdef CSC_DE_GATE_EN
    if (!ctl_d5[2] && !rst) begin
      y_out       = Y_OFF;
      c_out       = C_OFF;
      cr_flag_out = 1'b0;
    end
`else
`endif
  end

endmodule

// File: tb/tb_csc_rgb2ycc422_p.sv
// Scoreboard bench for csc_rgb2ycc422_p: expectations come from a reference
// colour-space model and are compared five cycles later at the output.
module tb_csc_rgb2ycc422_p;

  localparam int DW       = 8;
  localparam bit CR_FIRST = 1'b0;
  localparam int LAT      = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic csc_mode_in = 1'b0;
  logic [DW-1:0] r_in = '0, g_in = '0, b_in = '0;
  logic de_in = 1'b0, hsync_in = 1'b0, vsync_in = 1'b0;
  logic [DW-1:0] y_out, c_out;
  logic cr_flag_out, de_out, hsync_out, vsync_out;

  csc_rgb2ycc422_p #(.DW(DW), .CR_FIRST(CR_FIRST)) dut (
    .clk(clk), .rst(rst), .csc_mode_in(csc_mode_in),
    .r_in(r_in), .g_in(g_in), .b_in(b_in),
    .de_in(de_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .y_out(y_out), .c_out(c_out), .cr_flag_out(cr_flag_out),
    .de_out(de_out), .hsync_out(hsync_out), .vsync_out(vsync_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit chk_vid;
    bit chk_y;
    bit de, hs, vs;
    int y, c;
    bit cr;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_errors = 0;
  int model_mode = 0;
  int lr[16], lg[16], lb[16];

  // [mode][component Y/Cb/Cr][R,G,B]
  int coef_tbl[2][3][3] = '{
    '{'{1052, 2065, 401}, '{-607, -1192, 1799}, '{1799, -1507, -292}},
    '{'{750, 2515, 254},  '{-413, -1384, 1799}, '{1799, -1634, -164}}
  };

  function automatic int model_conv(input int mode, input int comp, input int r, input int g, input int b);
    int sum, v;
    sum = coef_tbl[mode][comp][0] * r + coef_tbl[mode][comp][1] * g + coef_tbl[mode][comp][2] * b;
    v = (sum + 2048) >>> 12;
    v += (comp == 0) ? (16 << (DW - 8)) : (128 << (DW - 8));
    if (v < 0) v = 0;
    if (v > (1 << DW) - 1) v = (1 << DW) - 1;
    return v;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, got, want, $time);
    end
  endtask

  task automatic applyStimulus(input bit de, input bit hs, input bit vs,
                               input int r, input int g, input int b, input exp_t e);
    @(posedge clk);
    #1;
    rst      = 1'b0;
    de_in    = de;
    hsync_in = hs;
    vsync_in = vs;
    r_in     = DW'(r);
    g_in     = DW'(g);
    b_in     = DW'(b);
    sb.push_back(e);
  endtask

  function automatic exp_t make_blank(input bit hs, input bit vs, input int r, input int g,
                                      input int b, input bit chk_y);
    exp_t e;
    e.de = 1'b0;
    e.hs = hs;
    e.vs = vs;
`ifdef CSC_DE_GATE_EN
    e.chk_vid = 1'b1;
    e.chk_y   = 1'b0;
    e.y       = 16 << (DW - 8);
    e.c       = 128 << (DW - 8);
    e.cr      = 1'b0;
`else
    e.chk_vid = 1'b0;
    e.chk_y   = chk_y;
    e.y       = model_conv(model_mode, 0, r, g, b);
    e.c       = 0;
    e.cr      = 1'b0;
`endif
    return e;
  endfunction

  task automatic blank_cycles(input int n, input bit hs, input bit vs, input int r,
                              input int g, input int b, input bit chk_y);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, hs, vs, r, g, b, make_blank(hs, vs, r, g, b, chk_y));
    end
  endtask

  task automatic vsync_pulse(input bit m);
    csc_mode_in = m;
    blank_cycles(2, 1'b0, 1'b0, 0, 0, 0, 1'b0);
    model_mode = int'(m);
    blank_cycles(3, 1'b0, 1'b1, 0, 0, 0, 1'b0);
    blank_cycles(3, 1'b0, 1'b0, 0, 0, 0, 1'b0);
  endtask

  task automatic hblank();
    blank_cycles(2, 1'b1, 1'b0, 0, 0, 0, 1'b0);
    blank_cycles(2, 1'b0, 1'b0, 0, 0, 0, 1'b0);
  endtask

  task automatic set_px(input int i, input int r, input int g, input int b);
    lr[i] = r;
    lg[i] = g;
    lb[i] = b;
  endtask

  // Drives the first n_drive pixels of an n-pixel line from lr/lg/lb.
  task automatic drive_line(input int n, input int n_drive);
    exp_t e;
    int j, ar, ag, ab;
    bit even, cr_slot;
    for (int i = 0; i < n_drive; i++) begin
      even = (i % 2 == 0);
      if (even) j = (i + 1 < n) ? i + 1 : i;
      else j = i - 1;
      ar = (lr[i] + lr[j] + 1) >> 1;
      ag = (lg[i] + lg[j] + 1) >> 1;
      ab = (lb[i] + lb[j] + 1) >> 1;
      cr_slot   = even ? CR_FIRST : !CR_FIRST;
      e.chk_vid = 1'b1;
      e.chk_y   = 1'b0;
      e.de      = 1'b1;
      e.hs      = 1'b0;
      e.vs      = 1'b0;
      e.y       = model_conv(model_mode, 0, lr[i], lg[i], lb[i]);
      e.c       = model_conv(model_mode, cr_slot ? 2 : 1, ar, ag, ab);
      e.cr      = cr_slot;
      applyStimulus(1'b1, 1'b0, 1'b0, lr[i], lg[i], lb[i], e);
    end
  endtask

  task automatic check_all_zero(input string tag);
    checkOutput({tag, "_y"}, 32'(y_out), 0);
    checkOutput({tag, "_c"}, 32'(c_out), 0);
    checkOutput({tag, "_cr"}, 32'(cr_flag_out), 0);
    checkOutput({tag, "_de"}, 32'(de_out), 0);
    checkOutput({tag, "_hs"}, 32'(hsync_out), 0);
    checkOutput({tag, "_vs"}, 32'(vsync_out), 0);
  endtask

  // Output monitor: one scoreboard entry per cycle, LAT cycles behind input.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && sb.size() > LAT) begin
        e = sb.pop_front();
        checkOutput("de_out", 32'(de_out), 32'(e.de));
        checkOutput("hsync_out", 32'(hsync_out), 32'(e.hs));
        checkOutput("vsync_out", 32'(vsync_out), 32'(e.vs));
        if (e.chk_vid) begin
          checkOutput("y_out", 32'(y_out), 32'(e.y));
          checkOutput("c_out", 32'(c_out), 32'(e.c));
          checkOutput("cr_flag_out", 32'(cr_flag_out), 32'(e.cr));
        end else if (e.chk_y) begin
          checkOutput("blank_y_out", 32'(y_out), 32'(e.y));
        end
      end
    end
  end

  initial begin
    #12;
    check_all_zero("reset");

    vsync_pulse(1'b0);
    hblank();

    // White line of four pixels.
    for (int i = 0; i < 4; i++) set_px(i, 255, 255, 255);
    drive_line(4, 4);
    hblank();

    // Red then black pair.
    set_px(0, 255, 0, 0);
    set_px(1, 0, 0, 0);
    drive_line(2, 2);
    hblank();

    // Mode request mid-frame must not take effect yet.
    csc_mode_in = 1'b1;
    hblank();
    set_px(0, 255, 0, 0);
    set_px(1, 255, 0, 0);
    drive_line(2, 2);
    hblank();

    vsync_pulse(1'b1);
    set_px(0, 255, 0, 0);
    set_px(1, 255, 0, 0);
    drive_line(2, 2);
    hblank();

    // Odd line length: the last pixel pairs with itself.
    for (int i = 0; i < 3; i++) set_px(i, 255, 255, 255);
    drive_line(3, 3);
    hblank();

    // Blanking with full-scale RGB.
    blank_cycles(4, 1'b0, 1'b0, 255, 255, 255, 1'b1);
    hblank();

    // Random odd-length line under BT.601.
    vsync_pulse(1'b0);
    for (int i = 0; i < 9; i++) set_px(i, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
    drive_line(9, 9);
    hblank();

    // Random even-length line under BT.709.
    vsync_pulse(1'b1);
    for (int i = 0; i < 8; i++) set_px(i, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
    drive_line(8, 8);
    hblank();

    // Asynchronous reset in the middle of an active line.
    for (int i = 0; i < 8; i++) set_px(i, 255, 255, 255);
    drive_line(8, 7);
    #3;
    rst = 1'b1;
    #1;
    check_all_zero("midline_reset");
    de_in       = 1'b0;
    hsync_in    = 1'b0;
    vsync_in    = 1'b0;
    r_in        = '0;
    g_in        = '0;
    b_in        = '0;
    csc_mode_in = 1'b0;
    model_mode  = 0;
    sb.delete();
    repeat (3) @(posedge clk);

    blank_cycles(3, 1'b0, 1'b0, 0, 0, 0, 1'b0);
    set_px(0, 255, 0, 0);
    set_px(1, 0, 0, 0);
    drive_line(2, 2);
    blank_cycles(10, 1'b0, 1'b0, 0, 0, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
